piccolo_con_rev_seq: RTL and testbench
======================================

# piccolo_con_rev_seq

Sequencer that delivers the Piccolo key-schedule constant pairs (con2i, con2i+1) in descending round order, last round first, for the decryption datapath. It sits between the decryption control FSM and the round-key XOR stage. It emits one constant pair per accepted valid/ready beat, so the decryption rounds receive their constants in reverse without a stored table.

## Interface
- No parameters. The round count is set by `key128` and the configuration macro.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `key128` input 1: 1 selects 31 rounds, 0 selects 25 rounds; sampled with `start`.
- `out_ready` input 1: consumer accepts the current beat.
- `out_valid` output 1: `con1`/`con2`/`round` are valid.
- `con1` output 16: con2i, the low half of the constant word.
- `con2` output 16: con2i+1, the high half of the constant word.
- `round` output 5: round index i of the current beat.
- `last` output 1: current beat is i = 0.
- `busy` output 1: FSM not in IDLE.
- `done` output 1: one-cycle pulse after the final beat is accepted.

## Operation
- Constant word, with ci = i+1 as a 5-bit value and c0 = 0:
  - bits [4:0] = ci, [9:5] = 0, [14:10] = ci, [16:15] = 0, [21:17] = ci, [26:22] = 0, [31:27] = ci.
  - The word is XORed with 32'h0F1E2D3C.
  - `con1` = word[15:0], `con2` = word[31:16].
- ci is modulo 32 and never overflows in the legal range (i ≤ 30).
- The FSM has three states.
- IDLE:
  - `out_valid` = 0, `busy` = 0.
  - On `start` = 1: load count = 24, or 30 when 128-bit is selected and enabled. Go to RUN.
- RUN:
  - `out_valid` = 1 and `round` = count.
  - The constants are registered and always correspond to the current `round`.
  - A beat is accepted on a cycle with `out_valid` && `out_ready`.
  - Accept with count > 0: count decrements, and the constants for count-1 are registered at the same edge.
  - Accept with count = 0: go to DONE.
- DONE:
  - `out_valid` = 0, `done` = 1 for exactly one cycle, then go to IDLE.
- `start` while `busy` is ignored, and the sequence is not restarted.
- `key128` changes after the `start` sample have no effect.
- While `out_valid` && !`out_ready`, `con1`, `con2`, `round` and `last` must hold stable.
- `last` = 1 exactly when in RUN and count = 0.

## Timing
- Reset (`rst_n` = 0 at an edge) puts every output at 0:
  - FSM = IDLE, count = 0.
  - `out_valid`, `busy`, `done`, `last` = 0.
  - `round`, `con1`, `con2` = 0.
- Reset asserted mid-sequence aborts it at that edge. No `done` pulse is generated.
- `start` sampled at edge k:
  - `out_valid` = 1 from edge k.
  - The first constants are visible in the cycle after edge k.
  - `busy` = 1 from edge k.
- Throughput: one beat per cycle while `out_ready` = 1. There is no bubble between beats.
- Full sequence with `out_ready` held 1, from the `start` edge to `done`:
  - 25 RUN cycles, then 1 DONE cycle (80-bit).
  - 31 RUN cycles, then 1 DONE cycle (128-bit).
- The earliest next `start` is accepted on the cycle after `done` (IDLE).
- A `start` asserted during the DONE cycle is ignored.
- There is no combinational path from `out_ready` to any output.

## Configuration
- `PICCOLO_CON_128_EN` defined:
  - `key128` is honored.
  - 128-bit sequences start at i = 30.
- `PICCOLO_CON_128_EN` undefined:
  - `key128` is ignored and unconnected internally.
  - Every sequence starts at i = 24.
  - Counter width stays 5 bits.

## Test plan
- Reset, then `start` with `key128` = 0 and `out_ready` = 1:
  - First beat: `round` = 24, `con1` = 16'h4925, `con2` = 16'hC72C.
  - Final beat: `round` = 0, `last` = 1, `con1` = 16'h293D, `con2` = 16'h071C.
  - `done` pulses 1 cycle after the final beat. Total 25 beats.
- Build with `PICCOLO_CON_128_EN`, `start` with `key128` = 1:
  - First beat: `round` = 30, `con1` = 16'h5123, `con2` = 16'hF720.
  - 31 beats in total.
  - Compare every beat against a reference model computed from the formula.
- Build without `PICCOLO_CON_128_EN`, `start` with `key128` = 1:
  - First beat: `round` = 24.
  - 25 beats in total.
- Random `out_ready` backpressure, including a 5-cycle stall on `round` = 10:
  - Outputs stay frozen through the stall.
  - No beat is skipped or duplicated.
  - `round` is strictly descending.
- Reset and `start` edge cases:
  - `rst_n` = 0 at `round` = 12: the next cycle shows all outputs 0 and no `done`.
  - `start` pulsed during RUN and during the DONE cycle: both are ignored, and the sequence count is unchanged.

Source files
------------

// File: rtl/piccolo_con_rev_seq_if.sv
// piccolo_con_rev_seq_if: start/stream handshake bundle between the decryption control FSM
// and the reverse-order Piccolo constant sequencer.
interface piccolo_con_rev_seq_if;
    logic        start;
    logic        key128;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] con1;
    logic [15:0] con2;
    logic [4:0]  round;
    logic        last;
    logic        busy;
    logic        done;
    modport master (
        output start, key128, out_ready,
        input  out_valid, con1, con2, round, last, busy, done
    );
    modport slave (
        input  start, key128, out_ready,
        output out_valid, con1, con2, round, last, busy, done
    );
endinterface

// File: rtl/piccolo_con_rev_seq.sv
// piccolo_con_rev_seq: emits Piccolo key-schedule constant pairs last round first, one per beat.
// Build macro PICCOLO_CON_128_EN enables the 31-round (128-bit key) sequence via key128.
module piccolo_con_rev_seq (
    input logic                  clk,
    input logic                  rst_n,
    piccolo_con_rev_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] con_q, con_d;
    logic [4:0]  load;
    logic        launch;
    logic        accept;

    function automatic logic [31:0] con_word(input logic [4:0] i);
        logic [4:0] c;
        c = i + 5'd1;
        return {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h0F1E2D3C;
    endfunction

`ifdef PICCOLO_CON_128_EN
    assign load = bus.key128 ? 5'd30 : 5'd24;
`else
    logic unused_key128;
    assign unused_key128 = bus.key128;
    assign load          = 5'd24;
`endif

    assign launch = (state_q == IDLE) && bus.start;
    assign accept = (state_q == RUN) && bus.out_ready;

    // Constants are precomputed for the next count so the outputs never depend on out_ready.
    always_comb begin
        state_d = launch ? RUN :
                  (accept && count_q == 5'd0) ? DONE :
                  (state_q == DONE) ? IDLE : state_q;
        count_d = launch ? load :
                  (accept && count_q != 5'd0) ? count_q - 5'd1 : count_q;
        con_d   = (state_d == RUN) ? con_word(count_d) : con_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            con_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            con_q   <= con_d;
        end
    end

    assign bus.out_valid = state_q == RUN;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.last      = (state_q == RUN) && (count_q == 5'd0);
    assign bus.round     = count_q;
    assign bus.con1      = con_q[15:0];
    assign bus.con2      = con_q[31:16];
endmodule

// File: tb/tb_piccolo_con_rev_seq.sv
// tb_piccolo_con_rev_seq: scoreboard bench for the reverse-order Piccolo constant sequencer.
// Honors PICCOLO_CON_128_EN the same way as the design build.
module tb_piccolo_con_rev_seq;
    typedef struct packed {
        logic [4:0]  round;
        logic [15:0] con1;
        logic [15:0] con2;
        logic        last;
    } beat_t;

`ifdef PICCOLO_CON_128_EN
    localparam bit EN128 = 1'b1;
`else
    localparam bit EN128 = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    beats = 0;
    int    last_acc_cyc = -1;
    bit    mon_en = 1'b0;
    bit    hold_chk = 1'b0;
    beat_t prev_b;
    beat_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piccolo_con_rev_seq_if bus ();
    piccolo_con_rev_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t model(input int i);
        logic [31:0] c, w;
        beat_t b;
        c = 32'((i + 1) % 32);
        w = (c | (c << 10) | (c << 17) | (c << 27)) ^ 32'h0F1E2D3C;
        b.round = 5'(i);
        b.con1  = w[15:0];
        b.con2  = w[31:16];
        b.last  = (i == 0);
        return b;
    endfunction

    function automatic int first_of(input logic k);
        return (k && EN128) ? 30 : 24;
    endfunction

    // Scoreboard monitor: pops one expected beat per accepted handshake, checks holds on stalls.
    always @(negedge clk) begin
        if (!mon_en) hold_chk = 1'b0;
        else begin
            if (hold_chk && bus.out_valid)
                check("hold", {bus.round, bus.con1, bus.con2, bus.last}, prev_b);
            hold_chk = bus.out_valid && !bus.out_ready;
            prev_b   = {bus.round, bus.con1, bus.con2, bus.last};
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) check("extra_beat", 1, 0);
                else check("beat", {bus.round, bus.con1, bus.con2, bus.last}, sb.pop_front());
                beats++;
                if (bus.last) begin
                    last_acc_cyc = cyc;
                    check("last_con1", bus.con1, 16'h293D);
                    check("last_con2", bus.con2, 16'h071C);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check(tag, {bus.out_valid, bus.busy, bus.done, bus.last, bus.round, bus.con1, bus.con2}, 0);
    endtask

    task automatic run_seq(input logic k128, input bit bp, input bit inj);
        int first, start_cyc, done_cyc, stall;
        bit seen;
        first = first_of(k128);
        for (int i = first; i >= 0; i--) sb.push_back(model(i));
        beats = 0;
        stall = 0;
        seen  = 1'b0;
        bus.start = 1'b1;
        bus.key128 = k128;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        bus.key128 = ~k128;
        check("first_round", bus.round, 64'(first));
        check("first_busy", bus.busy, 1);
        if (first == 24) begin
            check("c1_r24", bus.con1, 16'h4925);
            check("c2_r24", bus.con2, 16'hC72C);
        end
        if (first == 30) begin
            check("c1_r30", bus.con1, 16'h5123);
            check("c2_r30", bus.con2, 16'hF720);
        end
        for (int n = 0; n < 300 && !seen; n++) begin
            if (bp) begin
                if (bus.out_valid && bus.round == 5'd10 && stall < 5) begin
                    bus.out_ready = 1'b0;
                    stall++;
                end else bus.out_ready = $urandom_range(0, 3) != 0;
            end
            bus.start = inj && bus.round == 5'd15;
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        done_cyc = cyc;
        check("done_seen", 64'(seen), 1);
        check("beats", 64'(beats), 64'(first + 1));
        check("sb_empty", 64'(sb.size()), 0);
        check("done_after_last", 64'(done_cyc), 64'(last_acc_cyc + 1));
        if (!bp) check("run_len", 64'(done_cyc - start_cyc), 64'(first + 1));
        if (bp) check("stall_len", 64'(stall), 5);
        check("done_valid", bus.out_valid, 0);
        sb.delete();
        bus.out_ready = 1'b1;
        bus.start = inj;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_pulse", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.out_valid, 0);
    endtask

    task automatic reset_mid;
        mon_en = 1'b0;
        bus.start = 1'b1;
        bus.key128 = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 40 && bus.round != 5'd12; n++) begin
            @(posedge clk); #1;
        end
        check("reach_12", bus.round, 12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("no_done", {bus.done, bus.busy}, 0);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key128 = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        run_seq(1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b0, 1'b0);
        run_seq(1'b0, 1'b1, 1'b0);
        run_seq(1'b0, 1'b0, 1'b1);
        reset_mid();
        run_seq(1'b1, 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
